cp0_unit: RTL and testbench

Parametrised coprocessor-0 for the MIPS core: Count/Compare timer with configurable divider, Status/Cause/EPC/BadVAddr/PRId/Config/Config1 registers, and exception/ERET commit from MEM/WB.
Replaces fixed-code exception decoding with explicit code/badvaddr inputs. Generates the masked interrupt request and the exception/ERET target PC for the PC unit.

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_timer.sv | 66 ++++++
 rtl/cp0_unit.sv | 148 ++++++++++++++
 tb/tb_cp0_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, selects, ExcCodes and field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  localparam logic [2:0] SEL0 = 3'd0;
  localparam logic [2:0] SEL1 = 3'd1;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_BEV   = 22;
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_IP_LO  = 8;
  localparam int unsigned CA_TI     = 30;
  localparam int unsigned CA_BD     = 31;

  localparam logic [31:0] CONFIG_VALUE  = 32'h8000_0000;
  localparam logic [31:0] CONFIG1_VALUE = 32'h0000_0000;

  // True when a (register, select) pair addresses the given CP0 register.
  function automatic logic cp0_hit(input logic [4:0] a, input logic [2:0] s,
                                   input logic [4:0] ra, input logic [2:0] rs);
    return (a == ra) && (s == rs);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky TI flag.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          chg_q, chg_d;
  logic          ti_q, ti_d;

  // Next-state: prescaler, Count (write wins over increment), Compare, TI.
  // TI is raised one cycle after Count moves onto Compare; chg_q remembers
  // that Count changed so a static equality does not keep re-triggering.
  always_comb begin
    phase_d   = phase_q;
    count_d   = count_q;
    compare_d = compare_q;
    if (count_we_i) begin
      count_d = wdata_i;
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      count_d = count_q + 32'd1;
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
    if (compare_we_i) compare_d = wdata_i;
    chg_d = (count_d != count_q);
    ti_d  = compare_we_i ? 1'b0 : (ti_q | (chg_q & (count_q == compare_q)));
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      chg_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      chg_q     <= chg_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC/BadVAddr, timer, exception/ERET commit.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
  parameter logic [31:0] VEC_BEV1   = 32'hBFC0_0380,
  parameter logic [31:0] VEC_BEV0   = 32'h8000_0180
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [2:0]            wsel_i,
  input  logic [4:0]            raddr_i,
  input  logic [2:0]            rsel_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_pc_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  exc_has_bva_i,
  input  logic                  eret_i,
  output logic                  int_req_o,
  output logic [31:0]           target_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic        ie_q, ie_d, exl_q, exl_d, bev_q, bev_d, bd_q, bd_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_q, exc_d;
  logic [1:0]  swip_q, swip_d;
  logic [5:0]  hwip_q, hwip_d;
  logic [31:0] epc_q, epc_d, bva_q, bva_d;
  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = we_i && cp0_hit(waddr_i, wsel_i, CP0_COUNT, SEL0);
  assign wr_compare = we_i && cp0_hit(waddr_i, wsel_i, CP0_COMPARE, SEL0);
  assign wr_status  = we_i && cp0_hit(waddr_i, wsel_i, CP0_STATUS, SEL0);
  assign wr_cause   = we_i && cp0_hit(waddr_i, wsel_i, CP0_CAUSE, SEL0);
  assign wr_epc     = we_i && cp0_hit(waddr_i, wsel_i, CP0_EPC, SEL0);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .wdata_i      (data_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Next-state: MTC0 first, then ERET, then exception, so later assignments
  // take priority on overlapping fields while disjoint MTC0 fields survive.
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    bev_d  = bev_q;
    im_d   = im_q;
    bd_d   = bd_q;
    exc_d  = exc_q;
    swip_d = swip_q;
    epc_d  = epc_q;
    bva_d  = bva_q;
    hwip_d = '0;
    hwip_d[NUM_HW_INT-1:0] = hw_int_i;
    if (wr_status) begin
      ie_d  = data_i[ST_IE];
      exl_d = data_i[ST_EXL];
      bev_d = data_i[ST_BEV];
      im_d  = data_i[ST_IM_LO +: 8];
    end
    if (wr_cause) swip_d = data_i[CA_IP_LO +: 2];
    if (wr_epc)   epc_d  = data_i;
    if (eret_i)   exl_d  = 1'b0;
    if (exc_valid_i) begin
      if (!exl_q) begin
        epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exl_d = 1'b1;
      exc_d = exc_code_i;
      if (exc_has_bva_i) bva_d = exc_badvaddr_i;
    end
  end

  // Architectural register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      bev_q  <= 1'b1;
      im_q   <= '0;
      bd_q   <= 1'b0;
      exc_q  <= '0;
      swip_q <= '0;
      hwip_q <= '0;
      epc_q  <= '0;
      bva_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      bev_q  <= bev_d;
      im_q   <= im_d;
      bd_q   <= bd_d;
      exc_q  <= exc_d;
      swip_q <= swip_d;
      hwip_q <= hwip_d;
      epc_q  <= epc_d;
      bva_q  <= bva_d;
    end
  end

  assign ip        = {hwip_q[5] | ti, hwip_q[4:0], swip_q};
  assign status_o  = {9'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_o   = {bd_q, ti, 14'b0, ip, 1'b0, exc_q, 2'b00};
  assign epc_o     = epc_q;
  assign int_req_o = ie_q & ~exl_q & (|(ip & im_q));
  assign target_pc_o = eret_i ? epc_q : (bev_q ? VEC_BEV1 : VEC_BEV0);

  // MFC0 read mux; reflects register contents before any same-cycle write.
  always_comb begin
    data_o = '0;
    case ({raddr_i, rsel_i})
      {CP0_BADVADDR, SEL0}: data_o = bva_q;
      {CP0_COUNT,    SEL0}: data_o = count;
      {CP0_COMPARE,  SEL0}: data_o = compare;
      {CP0_STATUS,   SEL0}: data_o = status_o;
      {CP0_CAUSE,    SEL0}: data_o = cause_o;
      {CP0_EPC,      SEL0}: data_o = epc_q;
      {CP0_PRID,     SEL0}: data_o = PRID_VALUE;
      {CP0_CONFIG,   SEL0}: data_o = CONFIG_VALUE;
      {CP0_CONFIG,   SEL1}: data_o = CONFIG1_VALUE;
      default:              data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: two instances (div 2 / 6 lines, div 1 / 4 lines).
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst, we, exc_valid, exc_bd, exc_has_bva, eret;
  logic [5:0]  hw_int;
  logic [4:0]  waddr, raddr, exc_code;
  logic [2:0]  wsel, rsel;
  logic [31:0] wdata, exc_pc, exc_bva;

  logic [31:0] a_data, a_tpc, a_st, a_ca, a_epc, b_data, b_tpc, b_st, b_ca, b_epc;
  logic        a_irq, b_irq;

  always #5 clk = ~clk;

  cp0_unit #(.NUM_HW_INT(6), .COUNT_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .hw_int_i(hw_int), .we_i(we), .waddr_i(waddr),
    .wsel_i(wsel), .raddr_i(raddr), .rsel_i(rsel), .data_i(wdata),
    .data_o(a_data), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .exc_bd_i(exc_bd), .exc_pc_i(exc_pc), .exc_badvaddr_i(exc_bva),
    .exc_has_bva_i(exc_has_bva), .eret_i(eret), .int_req_o(a_irq),
    .target_pc_o(a_tpc), .status_o(a_st), .cause_o(a_ca), .epc_o(a_epc));

  cp0_unit #(.NUM_HW_INT(4), .COUNT_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .hw_int_i(hw_int[3:0]), .we_i(we), .waddr_i(waddr),
    .wsel_i(wsel), .raddr_i(raddr), .rsel_i(rsel), .data_i(wdata),
    .data_o(b_data), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .exc_bd_i(exc_bd), .exc_pc_i(exc_pc), .exc_badvaddr_i(exc_bva),
    .exc_has_bva_i(exc_has_bva), .eret_i(eret), .int_req_o(b_irq),
    .target_pc_o(b_tpc), .status_o(b_st), .cause_o(b_ca), .epc_o(b_epc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Count is base + elapsed_cycles / divider since the last reset or write.
  int unsigned cyc = 0;
  logic [31:0] m_base[2];
  int unsigned m_t0[2];
  logic        m_ti[2], m_pend[2];
  logic [5:0]  m_hw[2];
  logic [31:0] m_cmp, m_epc, m_bva;
  logic        m_ie, m_exl, m_bev, m_bd;
  logic [7:0]  m_im;
  logic [4:0]  m_exc;
  logic [1:0]  m_sw;

  function automatic int unsigned div_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] m_count(int i, int unsigned c);
    return m_base[i] + 32'((c - m_t0[i]) / div_of(i));
  endfunction

  function automatic logic [31:0] m_status();
    return {9'b0, m_bev, 6'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [7:0] m_ip(int i);
    return {m_hw[i][5] | m_ti[i], m_hw[i][4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_cause(int i);
    return {m_bd, m_ti[i], 14'b0, m_ip(i), 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic m_irq(int i);
    return m_ie & ~m_exl & (|(m_ip(i) & m_im));
  endfunction

  function automatic logic [31:0] m_tpc();
    return eret ? m_epc : (m_bev ? 32'hBFC0_0380 : 32'h8000_0180);
  endfunction

  function automatic logic [31:0] m_read(int i);
    if (rsel != 3'd0) return 32'h0;
    case (raddr)
      5'd8:    return m_bva;
      5'd9:    return m_count(i, cyc);
      5'd11:   return m_cmp;
      5'd12:   return m_status();
      5'd13:   return m_cause(i);
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h8000_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int unsigned nc = cyc + 1;
    logic w_cnt = we && waddr == 5'd9  && wsel == 3'd0;
    logic w_cmp = we && waddr == 5'd11 && wsel == 3'd0;
    logic w_st  = we && waddr == 5'd12 && wsel == 3'd0;
    logic w_ca  = we && waddr == 5'd13 && wsel == 3'd0;
    logic w_epc = we && waddr == 5'd14 && wsel == 3'd0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_base[i] = 32'h0; m_t0[i] = nc; m_ti[i] = 1'b0; m_pend[i] = 1'b0; m_hw[i] = 6'h0;
      end
      m_cmp = 0; m_epc = 0; m_bva = 0; m_ie = 0; m_exl = 0; m_bev = 1;
      m_bd = 0; m_im = 0; m_exc = 0; m_sw = 0;
    end else begin
      logic        old_exl = m_exl;
      logic [31:0] cmp_new = w_cmp ? wdata : m_cmp;
      for (int i = 0; i < 2; i++) begin
        logic [31:0] c_old, c_new;
        c_old = m_count(i, cyc);
        if (w_cnt) begin m_base[i] = wdata; m_t0[i] = nc; end
        c_new = m_count(i, nc);
        m_ti[i]   = w_cmp ? 1'b0 : (m_ti[i] | m_pend[i]);
        m_pend[i] = (c_new != c_old) && (c_new == cmp_new);
        m_hw[i]   = (i == 0) ? hw_int : {2'b00, hw_int[3:0]};
      end
      m_cmp = cmp_new;
      if (w_st) begin
        m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:8]; m_bev = wdata[22];
      end
      if (w_ca)  m_sw  = wdata[9:8];
      if (w_epc) m_epc = wdata;
      if (eret)  m_exl = 1'b0;
      if (exc_valid) begin
        if (!old_exl) begin
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          m_bd  = exc_bd;
        end
        m_exl = 1'b1;
        m_exc = exc_code;
        if (exc_has_bva) m_bva = exc_bva;
      end
    end
    cyc = nc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; waddr = 0; wsel = 0; wdata = 0; raddr = 0; rsel = 0;
    exc_valid = 0; exc_code = 0; exc_bd = 0; exc_pc = 0; exc_bva = 0;
    exc_has_bva = 0; eret = 0; hw_int = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we = 1; waddr = a; wsel = s; wdata = d;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] d, st, ca, ep, tp;
      logic        irq;
      if (i == 0) begin d = a_data; st = a_st; ca = a_ca; ep = a_epc; tp = a_tpc; irq = a_irq; end
      else        begin d = b_data; st = b_st; ca = b_ca; ep = b_epc; tp = b_tpc; irq = b_irq; end
      chk($sformatf("rnd_data%0d_r%0d", i, raddr), d, m_read(i));
      chk($sformatf("rnd_status%0d", i), st, m_status());
      chk($sformatf("rnd_cause%0d", i), ca, m_cause(i));
      chk($sformatf("rnd_epc%0d", i), ep, m_epc);
      chk($sformatf("rnd_tpc%0d", i), tp, m_tpc());
      chk($sformatf("rnd_irq%0d", i), {31'b0, irq}, {31'b0, m_irq(i)});
    end
  endtask

  typedef struct {
    logic [4:0]  ra;
    logic [2:0]  rs;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[12];

  initial begin
    tbl[0]  = '{5'd14, 3'd0, 32'h1234_5678};
    tbl[1]  = '{5'd11, 3'd0, 32'h5555_0000};
    tbl[2]  = '{5'd15, 3'd0, 32'h0000_4220};
    tbl[3]  = '{5'd16, 3'd0, 32'h8000_0000};
    tbl[4]  = '{5'd16, 3'd1, 32'h0000_0000};
    tbl[5]  = '{5'd16, 3'd2, 32'h0000_0000};
    tbl[6]  = '{5'd12, 3'd0, 32'h0040_0000};
    tbl[7]  = '{5'd12, 3'd1, 32'h0000_0000};
    tbl[8]  = '{5'd8,  3'd0, 32'h0000_0000};
    tbl[9]  = '{5'd13, 3'd0, 32'h0000_0000};
    tbl[10] = '{5'd0,  3'd0, 32'h0000_0000};
    tbl[11] = '{5'd9,  3'd1, 32'h0000_0000};

    // Reset values and idle count.
    idle(); rst = 1; tick(); tick(); rst = 0;
    chk("rst_status_a", a_st, 32'h0040_0000);
    chk("rst_status_b", b_st, 32'h0040_0000);
    chk("rst_cause_a", a_ca, 32'h0);
    chk("rst_epc_a", a_epc, 32'h0);
    chk("rst_irq_a", {31'b0, a_irq}, 32'h0);
    chk("rst_tpc_a", a_tpc, 32'hBFC0_0380);
    chk("rst_tpc_b", b_tpc, 32'hBFC0_0380);
    repeat (10) tick();
    raddr = 5'd9; #1;
    chk("count_div2_10cyc", a_data, 32'd5);
    chk("count_div1_10cyc", b_data, 32'd10);

    // Read decode table, plus pre-write read and ignored writes.
    mtc0(5'd14, 3'd0, 32'h1234_5678); raddr = 5'd14; #1;
    chk("read_prewrite_epc", a_data, 32'h0);
    tick();
    mtc0(5'd11, 3'd0, 32'h5555_0000); tick();
    mtc0(5'd15, 3'd0, 32'hFFFF_FFFF); tick();
    mtc0(5'd8,  3'd0, 32'hFFFF_FFFF); tick();
    mtc0(5'd16, 3'd0, 32'h0);         tick();
    mtc0(5'd12, 3'd1, 32'hFFFF_FFFF); tick();
    we = 0;
    for (int k = 0; k < 12; k++) begin
      raddr = tbl[k].ra; rsel = tbl[k].rs; #1;
      chk($sformatf("tbl%0d_a", k), a_data, tbl[k].exp);
      chk($sformatf("tbl%0d_b", k), b_data, tbl[k].exp);
    end
    rsel = 0;

    // Timer match, sticky TI, Compare-write clear.
    rst = 1; tick(); rst = 0;
    mtc0(5'd12, 3'd0, 32'h0040_8001); tick();
    mtc0(5'd11, 3'd0, 32'd3); tick();
    we = 0; tick();
    chk("ti_b_before", {31'b0, b_ca[30]}, 32'h0);
    tick();
    chk("ti_b_set", {31'b0, b_ca[30]}, 32'h1);
    chk("irq_b_set", {31'b0, b_irq}, 32'h1);
    chk("ti_a_early", {31'b0, a_ca[30]}, 32'h0);
    tick(); tick();
    chk("ti_a_before", {31'b0, a_ca[30]}, 32'h0);
    tick();
    chk("ti_a_set", {31'b0, a_ca[30]}, 32'h1);
    chk("irq_a_set", {31'b0, a_irq}, 32'h1);
    chk("ti_b_sticky", {31'b0, b_ca[30]}, 32'h1);
    mtc0(5'd11, 3'd0, 32'd100); tick(); we = 0;
    chk("ti_a_clr", {31'b0, a_ca[30]}, 32'h0);
    chk("ti_b_clr", {31'b0, b_ca[30]}, 32'h0);
    chk("irq_a_clr", {31'b0, a_irq}, 32'h0);
    chk("irq_b_clr", {31'b0, b_irq}, 32'h0);
    mtc0(5'd9, 3'd0, 32'd98); tick(); we = 0;
    tick(); tick();
    chk("ti_b_pending", {31'b0, b_ca[30]}, 32'h0);
    mtc0(5'd11, 3'd0, 32'd200); tick(); we = 0;
    chk("ti_clear_beats_set", {31'b0, b_ca[30]}, 32'h0);
    tick();
    chk("ti_clear_stays", {31'b0, b_ca[30]}, 32'h0);

    // Count wrap and write during increment cycle.
    raddr = 5'd9;
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF); tick(); we = 0;
    tick();
    chk("wrap_b", b_data, 32'h0);
    chk("wrap_a_hold", a_data, 32'hFFFF_FFFF);
    tick();
    chk("wrap_a", a_data, 32'h0);
    tick();
    mtc0(5'd9, 3'd0, 32'd7); tick(); we = 0;
    chk("cntwr_a", a_data, 32'd7);
    chk("cntwr_b", b_data, 32'd7);
    tick();
    chk("cntwr_phase_a", a_data, 32'd7);
    chk("cntwr_next_b", b_data, 32'd8);
    tick();
    chk("cntwr_inc_a", a_data, 32'd8);

    // Exceptions: first sets EPC/BD/BadVAddr, nested one keeps EPC.
    exc_valid = 1; exc_code = 5'd4; exc_bd = 1; exc_pc = 32'h8000_1004;
    exc_bva = 32'h1233; exc_has_bva = 1; tick(); exc_valid = 0;
    raddr = 5'd8; #1;
    chk("exc1_epc", a_epc, 32'h8000_1000);
    chk("exc1_bd", {31'b0, a_ca[31]}, 32'h1);
    chk("exc1_code", {27'b0, a_ca[6:2]}, 32'd4);
    chk("exc1_bva", a_data, 32'h1233);
    chk("exc1_exl", {31'b0, a_st[1]}, 32'h1);
    exc_valid = 1; exc_code = 5'd10; exc_bd = 0; exc_pc = 32'h9000_0000;
    exc_bva = 32'hDEAD; exc_has_bva = 0; tick(); exc_valid = 0;
    chk("exc2_epc", b_epc, 32'h8000_1000);
    chk("exc2_code", {27'b0, a_ca[6:2]}, 32'd10);
    chk("exc2_bva", a_data, 32'h1233);
    chk("exc2_bd", {31'b0, a_ca[31]}, 32'h1);

    // ERET redirect and EXL clear.
    mtc0(5'd14, 3'd0, 32'h8000_2000); tick(); we = 0;
    eret = 1; #1;
    chk("eret_tpc_a", a_tpc, 32'h8000_2000);
    chk("eret_tpc_b", b_tpc, 32'h8000_2000);
    tick(); eret = 0; #1;
    chk("eret_exl", {31'b0, a_st[1]}, 32'h0);
    chk("eret_tpc_after", a_tpc, 32'hBFC0_0380);

    // Simultaneous MTC0 Status and exception.
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    exc_valid = 1; exc_code = 5'd12; exc_bd = 0; exc_pc = 32'h8000_3000; exc_has_bva = 0;
    tick(); we = 0; exc_valid = 0; #1;
    chk("mix_status_a", a_st, 32'h0000_FF03);
    chk("mix_status_b", b_st, 32'h0000_FF03);
    chk("mix_tpc", a_tpc, 32'h8000_0180);
    chk("mix_epc", a_epc, 32'h8000_3000);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: waddr = 5'd8;  1: waddr = 5'd9;  2: waddr = 5'd11; 3: waddr = 5'd12;
        4: waddr = 5'd13; 5: waddr = 5'd14; 6: waddr = 5'd16;
        default: waddr = 5'($urandom);
      endcase
      wsel  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
      wdata = $urandom;
      if (waddr == 5'd11 && $urandom_range(0, 1) == 1)
        wdata = m_count($urandom_range(0, 1), cyc) + $urandom_range(1, 6);
      if (waddr == 5'd9 && $urandom_range(0, 3) == 0)
        wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
      exc_valid   = ($urandom_range(0, 11) == 0);
      exc_code    = 5'($urandom);
      exc_bd      = 1'($urandom);
      exc_pc      = $urandom;
      exc_bva     = $urandom;
      exc_has_bva = 1'($urandom);
      eret        = ($urandom_range(0, 9) == 0);
      hw_int      = 6'($urandom);
      case ($urandom_range(0, 7))
        0: raddr = 5'd8;  1: raddr = 5'd9;  2: raddr = 5'd11; 3: raddr = 5'd12;
        4: raddr = 5'd13; 5: raddr = 5'd14; 6: raddr = 5'd15;
        default: raddr = 5'($urandom);
      endcase
      rsel = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
      #1;
      check_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
